serial_full_adder: RTL and testbench

//   Bit-serial N-bit adder: the carry-propagating counterpart of the full-subtractor datapath.

---
 rtl/serial_full_adder_if.sv | 25 ++
 rtl/serial_full_adder.sv | 146 ++++++++++++++
 tb/tb_serial_full_adder.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_full_adder_if.sv
// Handshake/operand bundle for serial_full_adder.
// ovf is present only when SERIAL_ADD_OVF_EN is defined.
interface serial_full_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

`ifdef SERIAL_ADD_OVF_EN
    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_full_adder.sv
// Bit-serial adder: a + b + cin, LSB first, one full-adder cell plus a carry flop.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_full_adder #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_full_adder_if.slave   bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_load;
    logic             w_step;
    logic             w_finish;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic [WIDTH-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_done;
`ifdef SERIAL_ADD_OVF_EN
    logic             r_carry_msb;
    logic             r_ovf;
`endif

    logic             w_s;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_sh_nxt;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    assign w_s    = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
    assign w_last = (r_cnt == CNT_LAST);

    // New sum bit enters at the MSB so the LSB ends up at bit 0 after WIDTH steps.
    always_comb begin
        w_sum_sh_nxt            = r_sum_sh >> 1;
        w_sum_sh_nxt[WIDTH-1]   = w_s;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_finish    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_sum_sh    <= '0;
            r_sum       <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_done      <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            r_carry_msb <= 1'b0;
            r_ovf       <= 1'b0;
`endif
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                r_a_sh  <= bus.a;
                r_b_sh  <= bus.b;
                r_carry <= bus.cin;
                r_cnt   <= '0;
            end
            if (w_step) begin
                r_carry  <= maj3(r_a_sh[0], r_b_sh[0], r_carry);
                r_sum_sh <= w_sum_sh_nxt;
                r_a_sh   <= r_a_sh >> 1;
                r_b_sh   <= r_b_sh >> 1;
                if (!w_last) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
`ifdef SERIAL_ADD_OVF_EN
                if (w_last) begin
                    r_carry_msb <= r_carry;
                end
`endif
            end
            // Results only change here, so the previous answer stays visible during RUN.
            if (w_finish) begin
                r_sum  <= r_sum_sh;
                r_cout <= r_carry;
`ifdef SERIAL_ADD_OVF_EN
                r_ovf  <= r_carry_msb ^ r_carry;
`endif
            end
        end
    end

    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
`ifdef SERIAL_ADD_OVF_EN
    assign bus.ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_full_adder.sv
// Directed and table-driven checks for serial_full_adder at WIDTH 1, 8 and 13.
module tb_serial_full_adder;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_full_adder_if #(.WIDTH(1))  ifc1 ();
    serial_full_adder_if #(.WIDTH(8))  ifc8 ();
    serial_full_adder_if #(.WIDTH(13)) ifc13 ();

    serial_full_adder #(.WIDTH(1))  u_w1  (.clk(clk), .rst_n(rst_n), .bus(ifc1));
    serial_full_adder #(.WIDTH(8))  u_w8  (.clk(clk), .rst_n(rst_n), .bus(ifc8));
    serial_full_adder #(.WIDTH(13)) u_w13 (.clk(clk), .rst_n(rst_n), .bus(ifc13));

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        int          w;
        logic [12:0] a;
        logic [12:0] b;
        logic        cin;
        logic [12:0] sum;
        logic        cout;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input int w, input logic st, input logic [12:0] a,
                         input logic [12:0] b, input logic c);
        case (w)
            1: begin ifc1.start = st; ifc1.a = a[0]; ifc1.b = b[0]; ifc1.cin = c; end
            8: begin ifc8.start = st; ifc8.a = a[7:0]; ifc8.b = b[7:0]; ifc8.cin = c; end
            default: begin ifc13.start = st; ifc13.a = a; ifc13.b = b; ifc13.cin = c; end
        endcase
    endtask

    function automatic logic rd_done(input int w);
        case (w)
            1: rd_done = ifc1.done;
            8: rd_done = ifc8.done;
            default: rd_done = ifc13.done;
        endcase
    endfunction

    function automatic logic rd_busy(input int w);
        case (w)
            1: rd_busy = ifc1.busy;
            8: rd_busy = ifc8.busy;
            default: rd_busy = ifc13.busy;
        endcase
    endfunction

    function automatic logic rd_cout(input int w);
        case (w)
            1: rd_cout = ifc1.cout;
            8: rd_cout = ifc8.cout;
            default: rd_cout = ifc13.cout;
        endcase
    endfunction

    function automatic logic [12:0] rd_sum(input int w);
        case (w)
            1: rd_sum = {12'd0, ifc1.sum};
            8: rd_sum = {5'd0, ifc8.sum};
            default: rd_sum = ifc13.sum;
        endcase
    endfunction

    // Operands are scrambled right after acceptance to prove they were captured.
    task automatic do_op(input int w, input logic [12:0] a, input logic [12:0] b, input logic c,
                         output logic [12:0] s, output logic co, output int lat, output int bcnt);
        @(negedge clk);
        drive(w, 1'b1, a, b, c);
        @(posedge clk);
        #1;
        drive(w, 1'b0, ~a, ~b, ~c);
        lat  = 0;
        bcnt = rd_busy(w) ? 1 : 0;
        while (!rd_done(w) && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
            if (rd_busy(w)) bcnt++;
        end
        if (!rd_done(w)) begin
            n_total++;
            $display("FAIL timeout_w%0d: no done within %0d cycles", w, lat);
        end
        s  = rd_sum(w);
        co = rd_cout(w);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [12:0] s;
        logic        co;
        int          lat;
        int          bcnt;
        int          dcount;
        logic [13:0] exp_full;
        logic [13:0] got_full;
        logic [12:0] ra;
        logic [12:0] rb;
        logic        rc;
        int          w;

        vecs[0] = '{8,  13'h05A, 13'h033, 1'b0, 13'h08D, 1'b0};
        vecs[1] = '{8,  13'h0FF, 13'h001, 1'b0, 13'h000, 1'b1};
        vecs[2] = '{8,  13'h0FF, 13'h0FF, 1'b1, 13'h0FF, 1'b1};
        vecs[3] = '{8,  13'h000, 13'h000, 1'b1, 13'h001, 1'b0};
        vecs[4] = '{8,  13'h080, 13'h080, 1'b0, 13'h000, 1'b1};
        vecs[5] = '{1,  13'h001, 13'h001, 1'b1, 13'h001, 1'b1};
        vecs[6] = '{1,  13'h000, 13'h001, 1'b0, 13'h001, 1'b0};
        vecs[7] = '{1,  13'h001, 13'h001, 1'b0, 13'h000, 1'b1};
        vecs[8] = '{13, 13'h1FFF, 13'h0001, 1'b0, 13'h0000, 1'b1};
        vecs[9] = '{13, 13'h0ABC, 13'h1234, 1'b1, 13'h1CF1, 1'b0};

        rst_n = 1'b0;
        drive(1, 1'b0, 13'd0, 13'd0, 1'b0);
        drive(8, 1'b0, 13'd0, 13'd0, 1'b0);
        drive(13, 1'b0, 13'd0, 13'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(ifc8.busy), 32'd0);
        chk("rst_done", 32'(ifc8.done), 32'd0);
        chk("rst_sum",  32'(ifc8.sum),  32'd0);
        chk("rst_cout", 32'(ifc8.cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        chk("rst_ovf",  32'(ifc8.ovf),  32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].cin, s, co, lat, bcnt);
            chk($sformatf("vec%0d_sum", i),  32'(s),    32'(vecs[i].sum));
            chk($sformatf("vec%0d_cout", i), 32'(co),   32'(vecs[i].cout));
            chk($sformatf("vec%0d_lat", i),  32'(lat),  32'(vecs[i].w + 1));
            chk($sformatf("vec%0d_busy", i), 32'(bcnt), 32'(vecs[i].w + 1));
        end

        // Result holds while idle.
        repeat (3) @(posedge clk);
        #1;
        chk("hold_sum", 32'(ifc8.sum), 32'h00);
        chk("hold_cout", 32'(ifc8.cout), 32'd1);

        // Start during RUN is ignored; back-to-back start after done is accepted.
        @(negedge clk);
        drive(8, 1'b1, 13'h05A, 13'h033, 1'b0);
        @(posedge clk);
        #1;
        drive(8, 1'b0, 13'd0, 13'd0, 1'b0);
        lat = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            lat++;
        end
        @(negedge clk);
        drive(8, 1'b1, 13'h001, 13'h001, 1'b0);
        @(posedge clk);
        #1;
        lat++;
        drive(8, 1'b0, 13'd0, 13'd0, 1'b0);
        while (!rd_done(8) && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("ign_lat", 32'(lat), 32'd9);
        chk("ign_sum", 32'(ifc8.sum), 32'h8D);
        do_op(8, 13'h010, 13'h020, 1'b0, s, co, lat, bcnt);
        chk("b2b_sum", 32'(s), 32'h30);
        chk("b2b_lat", 32'(lat), 32'd9);
        @(posedge clk);
        #1;
        chk("done_pulse", 32'(ifc8.done), 32'd0);

        // Reset in the middle of RUN discards the operation.
        do_op(8, 13'h0F0, 13'h020, 1'b0, s, co, lat, bcnt);
        chk("pre_rst_sum", 32'(s), 32'h10);
        chk("pre_rst_cout", 32'(co), 32'd1);
        @(negedge clk);
        drive(8, 1'b1, 13'h05A, 13'h033, 1'b0);
        @(posedge clk);
        #1;
        drive(8, 1'b0, 13'd0, 13'd0, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_busy", 32'(ifc8.busy), 32'd0);
        chk("mid_rst_done", 32'(ifc8.done), 32'd0);
        chk("mid_rst_sum",  32'(ifc8.sum),  32'd0);
        chk("mid_rst_cout", 32'(ifc8.cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (ifc8.done) dcount++;
        end
        chk("mid_rst_no_done", 32'(dcount), 32'd0);
        do_op(8, 13'h012, 13'h034, 1'b1, s, co, lat, bcnt);
        chk("post_rst_sum", 32'(s), 32'h47);
        chk("post_rst_cout", 32'(co), 32'd0);

`ifdef SERIAL_ADD_OVF_EN
        do_op(8, 13'h07F, 13'h001, 1'b0, s, co, lat, bcnt);
        chk("ovf_7f_01", 32'(ifc8.ovf), 32'd1);
        do_op(8, 13'h080, 13'h080, 1'b0, s, co, lat, bcnt);
        chk("ovf_80_80", 32'(ifc8.ovf), 32'd1);
        chk("ovf_80_80_cout", 32'(co), 32'd1);
        chk("ovf_80_80_sum", 32'(s), 32'h00);
        do_op(8, 13'h010, 13'h020, 1'b0, s, co, lat, bcnt);
        chk("ovf_10_20", 32'(ifc8.ovf), 32'd0);
`endif

        // Random operands against an arithmetic reference at WIDTH 8 and 13.
        for (int i = 0; i < 400; i++) begin
            w  = (i < 200) ? 8 : 13;
            ra = 13'($urandom);
            rb = 13'($urandom);
            rc = 1'($urandom);
            if (w == 8) begin
                ra = ra & 13'h0FF;
                rb = rb & 13'h0FF;
            end
            do_op(w, ra, rb, rc, s, co, lat, bcnt);
            exp_full = 14'(ra) + 14'(rb) + 14'(rc);
            if (w == 8) got_full = {5'd0, co, s[7:0]};
            else        got_full = {co, s};
            chk($sformatf("rand_w%0d_%0d", w, i), 32'(got_full), 32'(exp_full));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
